// File: rtl/iir_coef_loader_pkg.sv
// Shared constants and types for the biquad coefficient loader.
package iir_pkg;

  localparam int CW     = 64;
  localparam int WW     = 32;
  localparam int NWORDS = 10;

  localparam logic [63:0] COEF_ONE = 64'h3FF0_0000_0000_0000;

  // Word index of the final (a2 hi) word of a set.
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } state_t;

  // Coefficient slots; coefficient k occupies shadow words 2k (lo) and 2k+1 (hi).
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

endpackage

// File: rtl/iir_coef_loader_if.sv
// Valid/ready word stream carrying coefficient words into the loader.
interface iir_coef_loader_if #(
  parameter int WW = iir_pkg::WW
);

  logic          wr_valid;
  logic          wr_ready;
  logic [WW-1:0] wr_data;
  logic          wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);

endinterface

// File: rtl/iir_coef_loader_register.sv
// Plain enabled register with zero reset, used for the active coefficient bank.
module register #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/iir_coef_loader.sv
// Coefficient loader: collects ten words into a shadow bank and commits the
// full set to the active bank on the next sample tick, pre-negating a1/a2.
// CW must equal 2*WW.
module iir_coef_loader #(
  parameter int CW = iir_pkg::CW,
  parameter int WW = iir_pkg::WW
) (
  input  logic                clk,
  input  logic                rst,
  iir_coef_loader_if.slave    wr,
  input  logic                sample_tick,
  output logic [CW-1:0]       b0,
  output logic [CW-1:0]       b1,
  output logic [CW-1:0]       b2,
  output logic [CW-1:0]       a1,
  output logic [CW-1:0]       a2,
  output logic                pending,
  output logic                commit,
  output logic                err
);

  import iir_pkg::*;

  state_t        state;
  state_t        state_n;
  logic [3:0]    idx;
  logic [3:0]    idx_n;
  logic          ready_q;
  logic          err_n;
  logic          commit_stb;
  logic          accept;
  logic [WW-1:0] shadow [NWORDS];
  logic [CW-1:0] sh_b0;
  logic [CW-1:0] sh_b1;
  logic [CW-1:0] sh_b2;
  logic [CW-1:0] sh_a1;
  logic [CW-1:0] sh_a2;

  // The filter adds the feedback terms, so denominators are stored negated.
  function automatic logic [CW-1:0] neg_coef(input logic [CW-1:0] c);
    return {~c[CW-1], c[CW-2:0]};
  endfunction

  assign accept      = wr.wr_valid && ready_q;
  assign wr.wr_ready = ready_q;

  assign sh_b0 = {shadow[2*B0+1], shadow[2*B0]};
  assign sh_b1 = {shadow[2*B1+1], shadow[2*B1]};
  assign sh_b2 = {shadow[2*B2+1], shadow[2*B2]};
  assign sh_a1 = {shadow[2*A1+1], shadow[2*A1]};
  assign sh_a2 = {shadow[2*A2+1], shadow[2*A2]};

  // Next-state, word index, framing error and commit strobe.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    err_n      = 1'b0;
    commit_stb = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (wr.wr_last) begin
            err_n = 1'b1;
          end else begin
            state_n = LOAD;
            idx_n   = 4'd1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (idx == LAST_IDX && wr.wr_last) begin
            state_n = PENDING;
            idx_n   = 4'd0;
          end else if (idx == LAST_IDX || wr.wr_last) begin
            err_n   = 1'b1;
            state_n = IDLE;
            idx_n   = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      PENDING: begin
        if (sample_tick) begin
          commit_stb = 1'b1;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = 4'd0;
      end
    endcase
  end

  // Control registers; every status output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      ready_q <= 1'b0;
      pending <= 1'b0;
      commit  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      ready_q <= (state_n != PENDING);
      pending <= (state_n == PENDING);
      commit  <= commit_stb;
      err     <= err_n;
    end
  end

  // Shadow bank write; stale words are harmless because only full sets commit.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow[idx] <= wr.wr_data;
    end
  end

  // b0 resets to 1.0 so the filter starts as a pass-through.
  always_ff @(posedge clk) begin
    if (rst) begin
      b0 <= CW'(COEF_ONE);
    end else if (commit_stb) begin
      b0 <= sh_b0;
    end
  end

  register #(.W(CW)) u_b1 (.clk(clk), .rst(rst), .en(commit_stb), .d(sh_b1),           .q(b1));
  register #(.W(CW)) u_b2 (.clk(clk), .rst(rst), .en(commit_stb), .d(sh_b2),           .q(b2));
  register #(.W(CW)) u_a1 (.clk(clk), .rst(rst), .en(commit_stb), .d(neg_coef(sh_a1)), .q(a1));
  register #(.W(CW)) u_a2 (.clk(clk), .rst(rst), .en(commit_stb), .d(neg_coef(sh_a2)), .q(a2));

endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed and randomized bench for the coefficient loader.
module tb_iir_coef_loader;

  import iir_pkg::*;

  typedef struct {
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] e0, e1, e2, e3, e4;
    int          dly;
  } vec_t;

  logic        clk_fast = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic [63:0] b0, b1, b2, a1, a2;
  logic        pending, commit, err;

  int          checks = 0;
  int          errors = 0;
  int          spurious;
  logic [63:0] cur [5];
  logic [63:0] exp_act [5];
  vec_t        vt [3];

  iir_coef_loader_if #(.WW(32)) wr_if ();

  iir_coef_loader #(.CW(64), .WW(32)) dut (
    .clk         (clk_fast),
    .rst         (rst),
    .wr          (wr_if),
    .sample_tick (sample_tick),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .pending     (pending),
    .commit      (commit),
    .err         (err)
  );

  always #5 clk_fast = ~clk_fast;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_active(input string tag);
    chk({tag, "_b0"}, b0, exp_act[0]);
    chk({tag, "_b1"}, b1, exp_act[1]);
    chk({tag, "_b2"}, b2, exp_act[2]);
    chk({tag, "_a1"}, a1, exp_act[3]);
    chk({tag, "_a2"}, a2, exp_act[4]);
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input bit gaps, input bit rtick);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        wr_if.wr_valid = 1'b0;
        sample_tick    = rtick && ($urandom_range(0, 3) == 0);
        step();
        if (commit) spurious++;
      end
    end
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_last  = last;
    sample_tick    = rtick && ($urandom_range(0, 3) == 0);
    n = 0;
    while (!wr_if.wr_ready && n < 20) begin
      step();
      n++;
    end
    if (!wr_if.wr_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait actual=0 expected=1");
    end
    step();
    if (commit) spurious++;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    sample_tick    = 1'b0;
  endtask

  // Sends the first nwords of cur; the final one carries last_flag.
  task automatic send_set(input int nwords, input bit last_flag, input bit gaps, input bit rtick);
    logic [31:0] d;
    for (int k = 0; k < nwords; k++) begin
      d = (k % 2 == 1) ? cur[k/2][63:32] : cur[k/2][31:0];
      send_word(d, (k == nwords - 1) ? last_flag : 1'b0, gaps, rtick);
    end
  endtask

  task automatic do_commit(input string tag);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk({tag, "_commit"}, commit, 1);
    chk_active(tag);
    step();
    chk({tag, "_commit_end"}, commit, 0);
    chk({tag, "_ready_after"}, wr_if.wr_ready, 1);
  endtask

  task automatic use_vec(input int i);
    cur[0] = vt[i].c0; cur[1] = vt[i].c1; cur[2] = vt[i].c2;
    cur[3] = vt[i].c3; cur[4] = vt[i].c4;
  endtask

  task automatic expect_vec(input int i);
    exp_act[0] = vt[i].e0; exp_act[1] = vt[i].e1; exp_act[2] = vt[i].e2;
    exp_act[3] = vt[i].e3; exp_act[4] = vt[i].e4;
  endtask

  initial begin
    vt[0] = '{64'h3FE0000000000000, 64'h3FD0000000000000, 64'h3FC0000000000000,
              64'hBFF8000000000000, 64'h3FE8000000000000,
              64'h3FE0000000000000, 64'h3FD0000000000000, 64'h3FC0000000000000,
              64'h3FF8000000000000, 64'hBFE8000000000000, 3};
    vt[1] = '{64'h7FF8000000000001, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
              64'h0000000000000000, 64'h8000000000000000,
              64'h7FF8000000000001, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
              64'h8000000000000000, 64'h0000000000000000, 0};
    vt[2] = '{64'h3FF0000000000000, 64'hC000000000000000, 64'h0123456789ABCDEF,
              64'h4000000000000000, 64'h0123456789ABCDEF,
              64'h3FF0000000000000, 64'hC000000000000000, 64'h0123456789ABCDEF,
              64'hC000000000000000, 64'h8123456789ABCDEF, 5};

    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_last  = 1'b0;
    spurious       = 0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_ready_low", wr_if.wr_ready, 0);
    rst = 1'b0;
    step();
    chk("rst_ready", wr_if.wr_ready, 1);
    chk("rst_pending", pending, 0);
    chk("rst_commit", commit, 0);
    chk("rst_err", err, 0);
    exp_act[0] = COEF_ONE;
    for (int j = 1; j < 5; j++) exp_act[j] = 64'h0;
    chk_active("rst");

    // Table-driven full sets
    for (int i = 0; i < 3; i++) begin
      use_vec(i);
      send_set(10, 1'b1, 1'b0, 1'b0);
      chk("vec_pending", pending, 1);
      chk("vec_ready_low", wr_if.wr_ready, 0);
      repeat (vt[i].dly) step();
      chk("vec_no_early_commit", commit, 0);
      expect_vec(i);
      do_commit("vec");
    end

    // Tick coincides with the 10th word: must wait for the next tick
    use_vec(0);
    send_set(9, 1'b0, 1'b0, 1'b0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = cur[4][63:32];
    wr_if.wr_last  = 1'b1;
    sample_tick    = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    sample_tick    = 1'b0;
    chk("same_tick_commit", commit, 0);
    chk("same_tick_pending", pending, 1);
    step();
    chk("same_tick_commit2", commit, 0);
    chk_active("same_tick_hold");
    expect_vec(0);
    do_commit("same_tick");

    // wr_last early on word 4
    use_vec(1);
    send_set(4, 1'b1, 1'b0, 1'b0);
    chk("early_last_err", err, 1);
    chk("early_last_ready", wr_if.wr_ready, 1);
    chk("early_last_pending", pending, 0);
    step();
    chk("early_last_err_end", err, 0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("early_last_no_commit", commit, 0);
    chk_active("early_last_hold");
    send_set(10, 1'b1, 1'b0, 1'b0);
    chk("after_err_pending", pending, 1);
    expect_vec(1);
    do_commit("after_err");

    // wr_last missing on word 10
    use_vec(2);
    send_set(10, 1'b0, 1'b0, 1'b0);
    chk("no_last_err", err, 1);
    chk("no_last_pending", pending, 0);
    chk("no_last_ready", wr_if.wr_ready, 1);
    step();
    chk("no_last_err_end", err, 0);
    chk_active("no_last_hold");

    // Reset mid-load, then a clean set
    use_vec(2);
    send_set(6, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_pending", pending, 0);
    chk("midrst_ready", wr_if.wr_ready, 1);
    chk("midrst_b0", b0, COEF_ONE);
    use_vec(0);
    send_set(10, 1'b1, 1'b0, 1'b0);
    chk("midrst_set_pending", pending, 1);
    expect_vec(0);
    do_commit("midrst");

    // Randomized sets with gaps and stray ticks
    for (int s = 0; s < 200; s++) begin
      for (int j = 0; j < 5; j++) cur[j] = {$urandom, $urandom};
      spurious = 0;
      send_set(10, 1'b1, 1'b1, 1'b1);
      chk("rand_spurious_commit", 64'(spurious), 0);
      chk("rand_pending", pending, 1);
      repeat ($urandom_range(0, 4)) step();
      exp_act[0] = cur[0];
      exp_act[1] = cur[1];
      exp_act[2] = cur[2];
      exp_act[3] = cur[3] ^ 64'h8000_0000_0000_0000;
      exp_act[4] = cur[4] ^ 64'h8000_0000_0000_0000;
      do_commit("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
